// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide execute unit.
// Shift-add multiply and restoring divide on operand magnitudes, one radix-2
// step per cycle, with signs applied to the final result. Divide-by-zero and
// signed overflow are resolved at accept time without iterating.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_addr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic [4:0]      out_rd_addr
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST_STEP = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   counter;
  logic [2:0]      op_q;
  logic            neg_q;      // negate product / quotient
  logic            neg_r;      // negate remainder
  // hi:lo is the product register for multiply (multiplier shifts out of lo);
  // for divide hi is the partial remainder and lo shifts dividend out / quotient in.
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic [XLEN-1:0] opb;        // multiplicand or divisor magnitude

  // Accept-time decode
  logic            is_div;
  logic            a_signed;
  logic            b_signed;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            div_zero;
  logic            div_ovf;
  logic [XLEN-1:0] special_result;

  // Iteration datapath
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic [XLEN:0]   div_diff;
  logic [XLEN-1:0] step_hi;
  logic [XLEN-1:0] step_lo;

  // Final result formatting
  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s;
  logic [XLEN-1:0]   rem_s;
  logic [XLEN-1:0]   result;

  // Decode operand signedness, magnitudes and the divide special cases
  always_comb begin
    is_div   = funct3[2];
    // Signed dividend for DIV/REM; signed rs1 for MULH and MULHSU.
    a_signed = is_div ? ~funct3[0] : (funct3[1] ^ funct3[0]);
    b_signed = is_div ? ~funct3[0] : (funct3[1:0] == 2'b01);
    a_neg    = a_signed & rs1_data[XLEN-1];
    b_neg    = b_signed & rs2_data[XLEN-1];
    a_mag    = a_neg ? (~rs1_data + 1'b1) : rs1_data;
    b_mag    = b_neg ? (~rs2_data + 1'b1) : rs2_data;
    div_zero = is_div && (rs2_data == '0);
    div_ovf  = is_div && !funct3[0] && (rs1_data == MIN_NEG) && (rs2_data == '1);
    special_result = '0;
    if (div_zero) begin
      special_result = funct3[1] ? rs1_data : '1;
    end else if (div_ovf) begin
      special_result = funct3[1] ? '0 : MIN_NEG;
    end
  end

  // One radix-2 step of either shift-add multiply or restoring divide
  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opb} : '0);
    div_shift = {hi, lo[XLEN-1]};
    div_diff  = div_shift - {1'b0, opb};
    if (op_q[2]) begin
      // Remainder stays below the divisor, so XLEN bits always hold it.
      step_hi = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
      step_lo = {lo[XLEN-2:0], ~div_diff[XLEN]};
    end else begin
      step_hi = mul_sum[XLEN:1];
      step_lo = {mul_sum[0], lo[XLEN-1:1]};
    end
  end

  // Apply signs to the last step's value and pick the requested half/part
  always_comb begin
    prod   = {step_hi, step_lo};
    prod_s = neg_q ? (~prod + 1'b1) : prod;
    quo_s  = neg_q ? (~step_lo + 1'b1) : step_lo;
    rem_s  = neg_r ? (~step_hi + 1'b1) : step_hi;
    case (op_q)
      OP_MUL:                        result = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  result = prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               result = quo_s;
      OP_REM, OP_REMU:               result = rem_s;
      default:                       result = '0;
    endcase
  end

  // Control FSM with registered handshake outputs and iteration registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_rd_addr <= '0;
      counter     <= '0;
      op_q        <= OP_MUL;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      opb         <= '0;
    end else if (flush) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      counter   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_q        <= funct3;
            out_rd_addr <= rd_addr;
            neg_q       <= a_neg ^ b_neg;
            neg_r       <= a_neg;
            counter     <= '0;
            hi          <= '0;
            lo          <= is_div ? a_mag : b_mag;
            opb         <= is_div ? b_mag : a_mag;
            in_ready    <= 1'b0;
            if (div_zero || div_ovf) begin
              state     <= DONE;
              out_valid <= 1'b1;
              out_data  <= special_result;
            end else begin
              state     <= CALC;
            end
          end
        end
        CALC: begin
          hi <= step_hi;
          lo <= step_lo;
          if (counter == LAST_STEP) begin
            state     <= DONE;
            out_valid <= 1'b1;
            out_data  <= result;
          end else begin
            counter <= counter + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed RV32M vectors, latency checks,
// backpressure, flush and mid-operation reset.
module tb_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  funct3;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [4:0]  rd_addr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_rd_addr;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .funct3     (funct3),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .rd_addr    (rd_addr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_rd_addr(out_rd_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: every handshake pops one expected result
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_output: got 0x%08h rd %0d with empty scoreboard", out_data, out_rd_addr);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_data", out_data, e.data);
        check("out_rd_addr", {27'd0, out_rd_addr}, {27'd0, e.rd});
      end
    end
  end

  // Called at a negedge; returns just after the accept posedge
  task automatic accept_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd, input logic [31:0] exp, input bit push);
    int guard = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("in_ready_before_issue", {31'd0, in_ready}, 32'd1);
    funct3   = f3;
    rs1_data = a;
    rs2_data = b;
    rd_addr  = rd;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    // Operands changing after accept must have no effect
    rs1_data = ~a;
    rs2_data = b ^ 32'h5A5A_5A5A;
    rd_addr  = ~rd;
    funct3   = ~f3;
    if (push) sb.push_back('{data: exp, rd: rd});
  endtask

  // Counts negedges after accept until out_valid; returns at that negedge
  task automatic wait_out(input int lat);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!out_valid && k < 100);
    check("latency", k, lat);
  endtask

  // Full op with out_ready high; returns at the negedge after the handshake
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp, input int lat);
    accept_op(f3, a, b, rd, exp, 1'b1);
    wait_out(lat);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    bit seen;
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    funct3    = 3'd0;
    rs1_data  = '0;
    rs2_data  = '0;
    rd_addr   = '0;
    repeat (2) @(negedge clk);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_out_data", out_data, 32'd0);
    check("reset_out_rd_addr", {27'd0, out_rd_addr}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Multiplies
    run_op(3'b000, 32'd7, 32'd6, 5'd5, 32'd42, 33);
    run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000, 33);
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, 33);
    run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFF, 33);
    run_op(3'b000, 32'hFFFF_FFFD, 32'd5, 5'd4, 32'hFFFF_FFF1, 33);
    run_op(3'b000, 32'd0, 32'd12345, 5'd0, 32'd0, 33);
    run_op(3'b001, 32'hFFFF_FFFF, 32'd2, 5'd6, 32'hFFFF_FFFF, 33);

    // Divides
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFD, 33);
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'hFFFF_FFFF, 33);
    run_op(3'b101, 32'd100, 32'd7, 5'd9, 32'd14, 33);
    run_op(3'b111, 32'd100, 32'd7, 5'd10, 32'd2, 33);
    run_op(3'b100, 32'd7, 32'hFFFF_FFFE, 5'd11, 32'hFFFF_FFFD, 33);

    // Special divides
    run_op(3'b100, 32'd5, 32'd0, 5'd12, 32'hFFFF_FFFF, 1);
    run_op(3'b111, 32'd5, 32'd0, 5'd13, 32'd5, 1);
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000, 1);
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'd0, 1);

    // Backpressure: hold DONE for 10 cycles
    out_ready = 1'b0;
    accept_op(3'b101, 32'd100, 32'd7, 5'd16, 32'd14, 1'b1);
    wait_out(33);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_out_data", out_data, 32'd14);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_after_hs_out_valid", {31'd0, out_valid}, 32'd0);
    check("bp_after_hs_in_ready", {31'd0, in_ready}, 32'd1);
    run_op(3'b000, 32'd11, 32'd13, 5'd17, 32'd143, 33);

    // Flush overrides an accept in the same cycle
    funct3   = 3'b100;
    rs1_data = 32'd5;
    rs2_data = 32'd0;
    rd_addr  = 5'd18;
    in_valid = 1'b1;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    @(negedge clk);
    check("flush_accept_out_valid", {31'd0, out_valid}, 32'd0);
    check("flush_accept_in_ready", {31'd0, in_ready}, 32'd1);

    // Flush at CALC cycle 12
    accept_op(3'b000, 32'd1000, 32'd1000, 5'd19, 32'd0, 1'b0);
    repeat (13) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_in_ready", {31'd0, in_ready}, 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) seen = 1'b1;
      @(negedge clk);
    end
    check("flush_no_out_valid", {31'd0, seen}, 32'd0);
    run_op(3'b000, 32'd3, 32'd3, 5'd20, 32'd9, 33);

    // Reset at CALC cycle 20
    accept_op(3'b000, 32'd77, 32'd88, 5'd21, 32'd0, 1'b0);
    repeat (21) @(negedge clk);
    rst = 1'b1;
    #2;
    check("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_mid_out_data", out_data, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) seen = 1'b1;
      @(negedge clk);
    end
    check("rst_no_out_valid", {31'd0, seen}, 32'd0);
    run_op(3'b000, 32'd3, 32'd3, 5'd22, 32'd9, 33);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
